// File: rtl/memisland_arb_pkg.sv
// Shared types and the round-robin pick function for the memisland narrow-port arbiter.
// The *Cfg localparams set the configuration that the package types are sized for.
package memisland_arb_pkg;

    localparam int unsigned NumReqCfg  = 3;
    localparam int unsigned MaxTxnsCfg = 4;
    localparam int unsigned IdxWidth   = (NumReqCfg > 1) ? $clog2(NumReqCfg) : 1;
    localparam int unsigned FillWidth  = $clog2(MaxTxnsCfg + 1);

    typedef logic [IdxWidth-1:0]  req_idx_t;
    typedef logic [FillWidth-1:0] fill_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rr_pick_t;

    // First asserted request at or after ptr, wrapping modulo NumReqCfg.
    function automatic rr_pick_t rr_pick(input logic [NumReqCfg-1:0] req, input req_idx_t ptr);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < NumReqCfg; i++) begin
            j = 32'(ptr) + i;
            if (j >= NumReqCfg) j = j - NumReqCfg;
            if (!res.valid && req[j]) begin
                res.valid = 1'b1;
                res.idx   = req_idx_t'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/memisland_arb_id_fifo.sv
// In-order FIFO of requester indices, one entry per accepted narrow-port transaction.
// The caller never pushes when full and never pops when empty.
module memisland_arb_id_fifo
    import memisland_arb_pkg::*;
#(
    parameter int unsigned Depth = MaxTxnsCfg
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  req_idx_t push_data_i,
    input  logic     pop_i,
    output req_idx_t head_o,
    output logic     full_o,
    output logic     empty_o,
    output fill_t    fill_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    req_idx_t            mem_q [Depth];
    logic [PtrWidth-1:0] wptr_q;
    logic [PtrWidth-1:0] rptr_q;
    fill_t               fill_q;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push_i) wptr_q <= ptr_inc(wptr_q);
            if (pop_i)  rptr_q <= ptr_inc(rptr_q);
            case ({push_i, pop_i})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (fill_q == fill_t'(Depth));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;

endmodule

// File: rtl/memisland_narrow_arbiter.sv
// Round-robin arbiter sharing one narrow memisland port; routes responses back in issue order.
// Optional per-requester grant counters on perf_gnt_cnt_o with MEMISLAND_ARB_PERF_EN.
module memisland_narrow_arbiter
    import memisland_arb_pkg::*;
#(
    parameter int unsigned NumReq    = NumReqCfg,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTxns   = MaxTxnsCfg
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_req_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_strb_i,
    output logic [NumReq-1:0]               req_gnt_o,
    output logic [NumReq-1:0]               req_rvalid_o,
    output logic [DataWidth-1:0]            req_rdata_o,
    output logic                            mem_req_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic                            mem_we_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_strb_o,
    input  logic                            mem_gnt_i,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i,
    output logic [$clog2(MaxTxns+1)-1:0]    outstanding_o,
`ifdef MEMISLAND_ARB_PERF_EN
    output logic [NumReq*32-1:0]            perf_gnt_cnt_o,
`endif
    output logic                            resp_err_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    if (NumReq != NumReqCfg || MaxTxns != MaxTxnsCfg) begin : g_cfg_check
        $error("memisland_narrow_arbiter: NumReq/MaxTxns must match memisland_arb_pkg");
    end

    rr_pick_t pick;
    req_idx_t rr_ptr_q, lock_idx_q, sel_idx, head_idx, rr_ptr_next;
    logic     lock_q, sel_vld, accept, pop, fifo_full, fifo_empty, resp_err_q;
    fill_t    fill;

    // A stalled request keeps its requester selected so the downstream payload stays stable.
    always_comb begin
        pick        = rr_pick(req_req_i, rr_ptr_q);
        sel_idx     = lock_q ? lock_idx_q : pick.idx;
        sel_vld     = lock_q || pick.valid;
        rr_ptr_next = (sel_idx == req_idx_t'(NumReq - 1)) ? '0 : sel_idx + 1'b1;

        mem_req_o   = rst_ni && sel_vld && !fifo_full;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        if (mem_req_o) begin
            mem_addr_o  = req_addr_i[sel_idx*AddrWidth +: AddrWidth];
            mem_we_o    = req_we_i[sel_idx];
            mem_wdata_o = req_wdata_i[sel_idx*DataWidth +: DataWidth];
            mem_strb_o  = req_strb_i[sel_idx*StrbWidth +: StrbWidth];
        end

        accept    = mem_req_o && mem_gnt_i;
        req_gnt_o = '0;
        if (accept) req_gnt_o[sel_idx] = 1'b1;

        pop          = rst_ni && mem_rvalid_i && !fifo_empty;
        req_rvalid_o = '0;
        if (pop) req_rvalid_o[head_idx] = 1'b1;
        req_rdata_o  = rst_ni ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_q <= rr_ptr_next;
                lock_q   <= 1'b0;
            end else if (mem_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end
            if (mem_rvalid_i && fifo_empty) resp_err_q <= 1'b1;
        end
    end

    memisland_arb_id_fifo #(
        .Depth (MaxTxns)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (sel_idx),
        .pop_i       (pop),
        .head_o      (head_idx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .fill_o      (fill)
    );

    assign outstanding_o = fill;
    assign resp_err_o    = resp_err_q;

`ifdef MEMISLAND_ARB_PERF_EN
    logic [31:0] perf_cnt_q [NumReq];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumReq; i++) perf_cnt_q[i] <= '0;
        end else if (accept) begin
            perf_cnt_q[sel_idx] <= perf_cnt_q[sel_idx] + 32'd1;
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_perf_out
        assign perf_gnt_cnt_o[g*32 +: 32] = perf_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_memisland_narrow_arbiter.sv
// Directed bench for memisland_narrow_arbiter: round robin, lock, full, empty-pop error, reset.
// Also checks the grant counters when built with MEMISLAND_ARB_PERF_EN.
module tb_memisland_narrow_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [2:0]  req_req;
    logic [95:0] req_addr;
    logic [2:0]  req_we;
    logic [95:0] req_wdata;
    logic [11:0] req_strb;
    logic [2:0]  req_gnt;
    logic [2:0]  req_rvalid;
    logic [31:0] req_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [2:0]  outstanding;
    logic        resp_err;
`ifdef MEMISLAND_ARB_PERF_EN
    logic [95:0] perf_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [2:0] exp_gnt, exp_rv;
    int         exp_out;

    always #5 clk = ~clk;

    memisland_narrow_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_req_i     (req_req),
        .req_addr_i    (req_addr),
        .req_we_i      (req_we),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_gnt_o     (req_gnt),
        .req_rvalid_o  (req_rvalid),
        .req_rdata_o   (req_rdata),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wdata_o   (mem_wdata),
        .mem_strb_o    (mem_strb),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .outstanding_o (outstanding),
`ifdef MEMISLAND_ARB_PERF_EN
        .perf_gnt_cnt_o(perf_cnt),
`endif
        .resp_err_o    (resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_payload();
        for (int i = 0; i < 3; i++) begin
            req_addr[i*32 +: 32]  = 32'h2000_0000 + 32'(i * 16);
            req_wdata[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
            req_strb[i*4 +: 4]    = 4'hF;
            req_we[i]             = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        req_req    = 3'b000;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        init_payload();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        init_payload();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_gnt", 64'(req_gnt), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        rst_ni = 1'b1;

        // Test 1: all three requesting, response two cycles after each grant.
        for (int k = 0; k < 8; k++) begin
            req_req    = (k < 6) ? 3'b111 : 3'b000;
            mem_gnt    = 1'b1;
            mem_rvalid = (k >= 2);
            mem_rdata  = 32'hA000_0000 + 32'(k);
            #2;
            exp_gnt = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
            exp_rv  = (k >= 2) ? 3'(1 << ((k - 2) % 3)) : 3'b000;
            exp_out = (k == 0) ? 0 : (k == 1) ? 1 : (k <= 6) ? 2 : 1;
            chk("t1_gnt", 64'(req_gnt), 64'(exp_gnt));
            chk("t1_rvalid", 64'(req_rvalid), 64'(exp_rv));
            chk("t1_outstanding", 64'(outstanding), 64'(exp_out));
            if (k < 6) chk("t1_addr", 64'(mem_addr), 64'(32'h2000_0000 + 32'((k % 3) * 16)));
            if (k >= 2) chk("t1_rdata", 64'(req_rdata), 64'(32'hA000_0000 + 32'(k)));
            cyc();
        end
        idle_inputs();
        #2;
        chk("t1_drained", 64'(outstanding), 64'd0);
        cyc();

        // Test 2: requester 1 write stalled three cycles; requester 0 arrives mid-stall.
        do_reset();
        req_addr[63:32]  = 32'h1000_0040;
        req_wdata[63:32] = 32'hDEAD_BEEF;
        req_strb[7:4]    = 4'hF;
        req_we[1]        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_req = (k == 2) ? 3'b111 : 3'b110;
            mem_gnt = 1'b0;
            #2;
            chk("t2_stall_req", 64'(mem_req), 64'd1);
            chk("t2_stall_addr", 64'(mem_addr), 64'h1000_0040);
            chk("t2_stall_we", 64'(mem_we), 64'd1);
            chk("t2_stall_gnt", 64'(req_gnt), 64'd0);
            cyc();
        end
        mem_gnt = 1'b1;
        #2;
        chk("t2_gnt1", 64'(req_gnt), 64'b010);
        chk("t2_addr1", 64'(mem_addr), 64'h1000_0040);
        chk("t2_wdata1", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("t2_strb1", 64'(mem_strb), 64'hF);
        cyc();
        req_req = 3'b101;
        #2;
        chk("t2_gnt2", 64'(req_gnt), 64'b100);
        chk("t2_addr2", 64'(mem_addr), 64'h2000_0020);
        cyc();
        req_req = 3'b001;
        #2;
        chk("t2_gnt0", 64'(req_gnt), 64'b001);
        cyc();
        idle_inputs();
        #2;
        chk("t2_outstanding", 64'(outstanding), 64'd3);
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5000_0000 + 32'(k);
            #2;
            exp_rv = (k == 0) ? 3'b010 : (k == 1) ? 3'b100 : 3'b001;
            chk("t2_rvalid", 64'(req_rvalid), 64'(exp_rv));
            chk("t2_rdata", 64'(req_rdata), 64'(32'h5000_0000 + 32'(k)));
            cyc();
        end
        idle_inputs();

        // Test 3: fill to MaxTxns with no responses.
        do_reset();
        req_req = 3'b111;
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            exp_gnt = 3'(1 << (k % 3));
            chk("t3_gnt", 64'(req_gnt), 64'(exp_gnt));
            chk("t3_fill", 64'(outstanding), 64'(k));
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("t3_full_req", 64'(mem_req), 64'd0);
            chk("t3_full_gnt", 64'(req_gnt), 64'd0);
            chk("t3_full_fill", 64'(outstanding), 64'd4);
            cyc();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #2;
        chk("t3_pop_rvalid", 64'(req_rvalid), 64'b001);
        chk("t3_pop_rdata", 64'(req_rdata), 64'h1234_5678);
        chk("t3_pop_req", 64'(mem_req), 64'd0);
        chk("t3_pop_gnt", 64'(req_gnt), 64'd0);
        cyc();
        mem_rvalid = 1'b0;
        #2;
        chk("t3_after_fill", 64'(outstanding), 64'd3);
        chk("t3_after_gnt", 64'(req_gnt), 64'b010);
        cyc();
        #2;
        chk("t3_refull_fill", 64'(outstanding), 64'd4);
        chk("t3_refull_req", 64'(mem_req), 64'd0);

        // Test 4: response with nothing outstanding.
        do_reset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        #2;
        chk("t4_no_rvalid", 64'(req_rvalid), 64'd0);
        chk("t4_err_before", 64'(resp_err), 64'd0);
        cyc();
        mem_rvalid = 1'b0;
        #2;
        chk("t4_err_set", 64'(resp_err), 64'd1);
        repeat (3) cyc();
        #2;
        chk("t4_err_sticky", 64'(resp_err), 64'd1);
        cyc();

        // Test 5: reset with three transactions outstanding.
        req_req = 3'b111;
        mem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            exp_gnt = 3'(1 << k);
            chk("t5_gnt", 64'(req_gnt), 64'(exp_gnt));
            cyc();
        end
        #2;
        chk("t5_pre_fill", 64'(outstanding), 64'd3);
        chk("t5_pre_err", 64'(resp_err), 64'd1);
        rst_ni     = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("t5_rst_req", 64'(mem_req), 64'd0);
        chk("t5_rst_gnt", 64'(req_gnt), 64'd0);
        chk("t5_rst_rvalid", 64'(req_rvalid), 64'd0);
        chk("t5_rst_fill", 64'(outstanding), 64'd0);
        chk("t5_rst_err", 64'(resp_err), 64'd0);
        mem_rvalid = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
        #2;
        chk("t5_restart_gnt0", 64'(req_gnt), 64'b001);
        chk("t5_restart_fill", 64'(outstanding), 64'd0);
        cyc();
        #2;
        chk("t5_restart_gnt1", 64'(req_gnt), 64'b010);
        chk("t5_restart_fill1", 64'(outstanding), 64'd1);
        cyc();

`ifdef MEMISLAND_ARB_PERF_EN
        // Test 6: grant counters, 10 grants to requester 0 and 5 to requester 2.
        do_reset();
        #2;
        chk("t6_cnt_rst", 64'(perf_cnt), 64'd0);
        mem_gnt = 1'b1;
        for (int k = 0; k < 15; k++) begin
            req_req    = (k < 10) ? 3'b001 : 3'b100;
            mem_rvalid = (k > 0);
            #2;
            cyc();
        end
        req_req    = 3'b000;
        mem_rvalid = 1'b1;
        cyc();
        idle_inputs();
        #2;
        chk("t6_cnt0", 64'(perf_cnt[31:0]), 64'd10);
        chk("t6_cnt1", 64'(perf_cnt[63:32]), 64'd0);
        chk("t6_cnt2", 64'(perf_cnt[95:64]), 64'd5);
        chk("t6_fill", 64'(outstanding), 64'd0);
        chk("t6_err", 64'(resp_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
